dmem_port_arbiter: RTL
======================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port 64-bit data memory between the pipeline MEM stage and a debug/loader port.
//  Sits between the EX/MEM register and data_memory.
//  Drives p_stall into the hazard unit: while p_stall=1, PCWrite=0, IF_ID_Write=0 and all pipeline registers hold.
//  Flags misaligned and out-of-range addresses.
// PARAMETERS
//  DATA_W      64    data word width; memory is byte-addressed, word index = addr>>3
//  DEPTH       1024  memory depth in words; IDX_W = $clog2(DEPTH)
//  STARVE_MAX  4     consecutive cycles the debug port may wait before it wins priority
// PORTS
//  clock       in   1       system clock, rising edge
//  reset_n     in   1       asynchronous active-low reset
//  p_req       in   1       MEM-stage access (memread_ex_mem | memwrite_ex_mem)
//  p_we        in   1       1=store, 0=load
//  p_addr      in   64      byte address (alu_result_ex_mem)
//  p_wdata     in   DATA_W  store data
//  p_rdata     out  DATA_W  load data, valid when p_done & !p_we
//  p_done      out  1       pipeline access completes this cycle
//  p_stall     out  1       freeze pipeline this cycle
//  p_inv_addr  out  1       pipeline address invalid (feeds invMemAddr)
//  d_req       in   1       debug access request; held until d_gnt
//  d_we        in   1       debug write enable
//  d_addr      in   64      debug byte address
//  d_wdata     in   DATA_W  debug write data
//  d_gnt       out  1       debug request accepted this cycle
//  d_valid     out  1       debug read data valid
//  d_rdata     out  DATA_W  debug read data
//  d_err       out  1       debug address invalid; pulses with d_gnt, no memory access
//  mem_en      out  1       memory access enable
//  mem_we      out  1       memory write enable
//  mem_idx     out  IDX_W   memory word index
//  mem_wdata   out  DATA_W  memory write data
//  mem_rdata   in   DATA_W  memory read data, returned 1 cycle after mem_en & !mem_we
// BEHAVIOUR
//  Address validity
//  - Invalid if addr[2:0]!=0 or (addr>>3)>=DEPTH.
//  - Invalid pipeline request: p_inv_addr=1, p_done=1, p_stall=0, p_rdata=0, no mem access, state unchanged.
//  - Invalid debug request, once granted: d_gnt=1, d_err=1, no mem access.
//  States
//  - IDLE: memory free; arbitrate. All outputs are combinational from state, starve_cnt and inputs.
//  - P_RD: pipeline load in flight.
//  - D_RD: debug load in flight.
//  Priority in IDLE when both request
//  - Pipeline wins unless starve_cnt==STARVE_MAX; then debug wins.
//  - Losing pipeline request gets p_stall=1. Losing debug request waits (d_gnt=0).
//  Store grant (IDLE)
//  - mem_en=1, mem_we=1; p_done=1 (or d_gnt=1); state stays IDLE. Zero-stall store.
//  Load grant (IDLE)
//  - mem_en=1, mem_we=0.
//  - Pipeline: p_stall=1, next state P_RD. Debug: d_gnt=1, next state D_RD.
//  P_RD
//  - p_rdata=mem_rdata, p_done=1, p_stall=0; next state IDLE.
//  - No new grant this cycle; pending requests wait.
//  D_RD
//  - d_rdata=mem_rdata, d_valid=1; next state IDLE.
//  - A pipeline request present this cycle gets p_stall=1.
//  starve_cnt
//  - Increments (saturating at STARVE_MAX) each cycle d_req=1 and d_gnt=0.
//  - Clears on d_gnt.
//  Latency
//  - Load: 2 cycles (1 stall cycle). Store: 1 cycle.
//  - Worst-case debug wait: STARVE_MAX+2 cycles.
//  Reset and outputs
//  - reset_n low: state=IDLE, starve_cnt=0, all outputs 0. In-flight read discarded, no d_valid/p_done after reset.
//  - p_rdata and d_rdata are 0 outside their valid cycles.
//  - Requests changing while not granted are legal. The granted request's fields are sampled in the grant cycle only.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined:
//  - Adds outputs stall_cycles[31:0] (counts cycles p_stall=1) and dbg_grants[31:0] (counts d_gnt).
//  - Both counters wrap at 2^32 and are cleared by reset_n.
//  DMEM_ARB_STATS_EN undefined:
//  - Ports and counters are absent; behaviour otherwise identical.
// TESTING
//  - Reset: reset_n=0 mid-P_RD -> next edge all outputs 0, state IDLE; no p_done after release.
//  - Pipeline store p_addr=0x10, p_wdata=0xDEADBEEF -> same cycle mem_idx=2, mem_we=1, p_done=1, p_stall=0.
//  - Pipeline load p_addr=0x10 -> cycle0 p_stall=1, mem_en=1; cycle1 p_done=1, p_rdata=0xDEADBEEF.
//  - Pipeline loads every cycle + d_req held -> debug granted after exactly STARVE_MAX=4 waiting cycles; p_stall=1 that cycle.
//  - p_addr=0x13 -> p_inv_addr=1, p_done=1, mem_en=0; d_addr=DEPTH*8 -> d_gnt=1, d_err=1, mem_en=0.
//  - Debug load 0x10 then simultaneous pipeline load -> d_valid=1 with 0xDEADBEEF; pipeline stalled 2 cycles, then served.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_port_arbiter_if
//  Brief    : Pipeline, debug and memory-side signal bundle for the arbiter.
//  Revision : 1.0
// ============================================================================
interface dmem_port_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int IDX_W  = 10
);
    logic              p_req;
    logic              p_we;
    logic [63:0]       p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic [DATA_W-1:0] p_rdata;
    logic              p_done;
    logic              p_stall;
    logic              p_inv_addr;

    logic              d_req;
    logic              d_we;
    logic [63:0]       d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_en;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        output p_rdata, p_done, p_stall, p_inv_addr,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_valid, d_rdata, d_err,
        output mem_en, mem_we, mem_idx, mem_wdata,
        input  mem_rdata
    );

    // Requester / memory side
    modport master (
        output p_req, p_we, p_addr, p_wdata,
        input  p_rdata, p_done, p_stall, p_inv_addr,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_valid, d_rdata, d_err,
        input  mem_en, mem_we, mem_idx, mem_wdata,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_port_arbiter
//  Brief    : Shares one single-port data memory between the MEM stage and a
//             debug/loader port; optional counters under DMEM_ARB_STATS_EN.
//  Revision : 1.0
// ============================================================================
module dmem_port_arbiter #(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 1024,
    parameter int STARVE_MAX = 4
) (
    input  wire                  clock,
    input  wire                  reset_n,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]          stall_cycles,
    output logic [31:0]          dbg_grants,
`endif
    dmem_port_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_P_RD = 2'd1,
        S_D_RD = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   starve_cnt, starve_nxt;

    logic               p_inv, d_inv, p_ok, starve_max, d_win;

    assign p_inv      = (bus.p_addr[2:0] != 3'd0) || (bus.p_addr[63:3] >= 61'(DEPTH));
    assign d_inv      = (bus.d_addr[2:0] != 3'd0) || (bus.d_addr[63:3] >= 61'(DEPTH));
    assign p_ok       = bus.p_req && !p_inv;
    assign starve_max = (starve_cnt == CNT_W'(STARVE_MAX));
    // Debug takes the slot when the pipeline has no memory work or it has starved long enough
    assign d_win      = bus.d_req && (!p_ok || starve_max);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        starve_nxt     = starve_cnt;
        bus.p_rdata    = '0;
        bus.p_done     = 1'b0;
        bus.p_stall    = 1'b0;
        bus.p_inv_addr = 1'b0;
        bus.d_gnt      = 1'b0;
        bus.d_valid    = 1'b0;
        bus.d_rdata    = '0;
        bus.d_err      = 1'b0;
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_idx    = '0;
        bus.mem_wdata  = '0;
        // Outputs are forced quiet while reset is asserted
        if (reset_n) begin
            case (state)
                S_IDLE: begin
                    if (bus.p_req && p_inv) begin
                        bus.p_inv_addr = 1'b1;
                        bus.p_done     = 1'b1;
                    end
                    if (d_win) begin
                        bus.d_gnt   = 1'b1;
                        bus.p_stall = p_ok;
                        if (d_inv) begin
                            bus.d_err = 1'b1;
                        end else begin
                            bus.mem_en    = 1'b1;
                            bus.mem_we    = bus.d_we;
                            bus.mem_idx   = bus.d_addr[IDX_W+2:3];
                            bus.mem_wdata = bus.d_wdata;
                            if (!bus.d_we) state_nxt = S_D_RD;
                        end
                    end else if (p_ok) begin
                        bus.mem_en    = 1'b1;
                        bus.mem_we    = bus.p_we;
                        bus.mem_idx   = bus.p_addr[IDX_W+2:3];
                        bus.mem_wdata = bus.p_wdata;
                        if (bus.p_we) begin
                            bus.p_done = 1'b1;
                        end else begin
                            bus.p_stall = 1'b1;
                            state_nxt   = S_P_RD;
                        end
                    end
                end
                S_P_RD: begin
                    bus.p_rdata = bus.mem_rdata;
                    bus.p_done  = 1'b1;
                    state_nxt   = S_IDLE;
                end
                S_D_RD: begin
                    bus.d_rdata = bus.mem_rdata;
                    bus.d_valid = 1'b1;
                    state_nxt   = S_IDLE;
                    if (p_ok) begin
                        bus.p_stall = 1'b1;
                    end else if (bus.p_req) begin
                        bus.p_inv_addr = 1'b1;
                        bus.p_done     = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase

            if (bus.d_gnt) begin
                starve_nxt = '0;
            end else if (bus.d_req && !starve_max) begin
                starve_nxt = starve_cnt + 1'b1;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            dbg_grants   <= '0;
        end else begin
            if (bus.p_stall) stall_cycles <= stall_cycles + 32'd1;
            if (bus.d_gnt)   dbg_grants   <= dbg_grants + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire
